pin_cmd_scheduler: RTL and testbench
====================================

// Module: pin_cmd_scheduler
// PURPOSE
//  Sequences SPI-received command bytes onto the 64 Icoboard output pins, replacing direct decode-to-toggle.
//  Brings spi_rx byte_ready into the clk domain and buffers bytes in a FIFO.
//  Executes them in order: toggle/set/clear one pin, or timed wait between pin events.
//  Sits between spi_rx and the pins.
// PARAMETERS
//  FIFO_DEPTH   8         command FIFO entries, power of 2, >=2
//  SYNC_STAGES  2         byte_ready synchronizer flops, >=2
//  TICK_DIV     1000      clk cycles per wait tick, >=1
//  RESET_PINS   64'h0     pins value on reset and on CLEAR_ALL
// PORTS
//  clk           in   1   system clock (CLK at top level)
//  rst           in   1   asynchronous reset, active-high
//  byte_ready    in   1   spi_rx frame-done flag, SCLK domain, level; held until next frame
//  command_byte  in   8   spi_rx byte; stable while byte_ready high
//  pins          out  64  registered output pins
//  busy          out  1   FSM not IDLE or FIFO not empty
//  overflow      out  1   sticky: a byte was dropped on full FIFO
//  fifo_count    out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst=1): pins=RESET_PINS, FIFO empty, fifo_count=0, overflow=0, busy=0, state IDLE,
//   sync flops=1 (a byte_ready already high at reset release is NOT a new byte), wait counter=0.
//  Capture: byte_ready -> SYNC_STAGES flops -> rising-edge detect. On the edge cycle command_byte is
//   written to FIFO. If full and no pop that cycle: byte dropped, overflow<=1.
//   Full with pop in the same cycle: write accepted, count unchanged.
//  Command encoding (cmd[7:6] opcode, cmd[5:0] arg):
//   00 TOGGLE pins[arg]^=1 | 01 SET pins[arg]=1 | 10 CLEAR pins[arg]=0
//   11 arg 0..62: WAIT (arg+1)*TICK_DIV clk cycles
//   11 arg 63 (0xFF): CLEAR_ALL -- pins=RESET_PINS, overflow<=0
//  FSM, one command in flight:
//   IDLE: FIFO non-empty -> pop head into cmd_reg, -> EXEC; else stay.
//   EXEC (1 cycle): apply pin opcode / CLEAR_ALL at end of cycle -> IDLE.
//    WAIT opcode: load counter=(arg+1)*TICK_DIV-1 -> WAIT.
//   WAIT: counter decrements each cycle; at 0 -> IDLE. Pins frozen; FIFO keeps accepting.
//  Latency: FIFO write at edge E (idle, empty) -> pop at E+1 -> pins updated at E+2.
//   Back-to-back pin commands: one per 2 cycles.
//  WAIT arithmetic: counter width = clog2(64*TICK_DIV); no overflow at arg=62.
//  Pins change only in EXEC; all other bits hold.
//  pins are registered; no combinational path from any input.
//  overflow set and CLEAR_ALL in the same cycle: set wins (overflow=1).
//  Reset mid-WAIT or mid-EXEC: abort immediately, queued bytes discarded.
//  FIFO pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
// STRUCTURE
//  Package pin_sched_pkg: opcode localparams (OP_TOGGLE=2'b00, OP_SET, OP_CLEAR, OP_SPECIAL),
//   ARG_CLEAR_ALL=6'd63, FSM state encoding (IDLE, EXEC, WAIT).
//  Sub-module cmd_fifo: sync single-clock FIFO, 8-bit data, DEPTH param.
//   Ports: wr_en, wr_data, rd_en, rd_data, full, empty, count; async active-high rst.
//  Top of this block holds the synchronizer, edge detect, FSM, wait counter and pin register.
// TESTING
//  1 Reset with RESET_PINS=0 and byte_ready=1 held through release -> no capture, fifo_count=0,
//    pins=0, busy=0.
//  2 Send 0x05 then 0x45 (TOGGLE 5, SET 5) -> pins[5]=1 at E+2 of first write;
//    still 1 after the second; all other pins 0.
//  3 TICK_DIV=4: send 0x4A, 0xC2, 0x8A -> pins[10] rises, stays 1 for 12 cycles of WAIT,
//    then clears 2 cycles later; busy=0 afterwards.
//  4 FIFO_DEPTH=4: send 0xC3 then 6 bytes during WAIT -> first 4 queued (fifo_count=4), rest dropped,
//    overflow=1; send 0xFF -> overflow=0, pins=RESET_PINS.
//  5 Assert rst mid-WAIT with 3 queued -> pins=RESET_PINS, fifo_count=0, state IDLE same edge;
//    queued commands never executed.
//  6 Full FIFO, write on the pop cycle -> byte accepted, overflow stays 0, order preserved.

Source files
------------

// File: rtl/pin_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pin_sched_pkg
// Description : Opcode, argument and FSM state encodings for pin_cmd_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pin_sched_pkg;

    localparam logic [1:0] OP_TOGGLE  = 2'b00;
    localparam logic [1:0] OP_SET     = 2'b01;
    localparam logic [1:0] OP_CLEAR   = 2'b10;
    localparam logic [1:0] OP_SPECIAL = 2'b11;

    localparam logic [5:0] ARG_CLEAR_ALL = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] arg;
    } cmd_t;

    function automatic logic is_clear_all(input cmd_t c);
        return (c.op == OP_SPECIAL) && (c.arg == ARG_CLEAR_ALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pin_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pin_cmd_scheduler_if
// Description : Command-byte input and pin/status outputs of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface pin_cmd_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             byte_ready;
    logic [7:0]       command_byte;
    logic [63:0]      pins;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output byte_ready,
        output command_byte,
        input  pins,
        input  busy,
        input  overflow,
        input  fifo_count
    );

    modport slave (
        input  byte_ready,
        input  command_byte,
        output pins,
        output busy,
        output overflow,
        output fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Single-clock show-ahead FIFO of command bytes; count tells full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     wr_en,
    input  wire logic [7:0]               wr_data,
    input  wire logic                     rd_en,
    output logic      [7:0]               rd_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A write into a full FIFO is legal only when the head leaves the same cycle.
    assign w_wr_ok = wr_en && (!full || rd_en);
    assign w_rd_ok = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_wr_ok, w_rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pin_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pin_cmd_scheduler
// Description : Synchronises spi_rx bytes, queues them and executes pin/wait commands in order.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_cmd_scheduler #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          TICK_DIV    = 1000,
    parameter logic [63:0] RESET_PINS  = 64'h0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pin_cmd_scheduler_if.slave   bus
);
    import pin_sched_pkg::*;

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(64 * TICK_DIV);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    state_t                 state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [WAIT_W-1:0]      cnt_q, cnt_d;
    logic [63:0]            pins_q, pins_d;
    logic                   overflow_q, overflow_d;

    logic                   w_edge;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [7:0]             w_rd_data;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;
    logic [WAIT_W-1:0]      w_wait_load;

    // Flops reset high so a flag already high when reset drops is not seen as a new byte.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.byte_ready};
    assign prev_d = sync_q[SYNC_STAGES-1];
    assign w_edge = sync_q[SYNC_STAGES-1] && !prev_q;

    assign w_pop  = (state_q == ST_IDLE) && !w_empty;
    assign w_push = w_edge && (!w_full || w_pop);
    assign w_drop = w_edge && w_full && !w_pop;

    assign w_wait_load = WAIT_W'((32'(cmd_q.arg) + 32'd1) * 32'(TICK_DIV) - 32'd1);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (bus.command_byte),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        pins_d     = pins_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    cmd_d   = cmd_t'(w_rd_data);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (cmd_q.op)
                    OP_TOGGLE: pins_d[cmd_q.arg] = !pins_q[cmd_q.arg];
                    OP_SET:    pins_d[cmd_q.arg] = 1'b1;
                    OP_CLEAR:  pins_d[cmd_q.arg] = 1'b0;
                    default: begin
                        if (is_clear_all(cmd_q)) begin
                            pins_d     = RESET_PINS;
                            overflow_d = 1'b0;
                        end else begin
                            cnt_d   = w_wait_load;
                            state_d = ST_WAIT;
                        end
                    end
                endcase
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A drop in the same cycle as CLEAR_ALL must still be reported.
        if (w_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            pins_q     <= RESET_PINS;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            pins_q     <= pins_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.pins       = pins_q;
    assign bus.busy       = (state_q != ST_IDLE) || !w_empty;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_pin_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pin_cmd_scheduler
// Description : Directed self-checking bench for pin_cmd_scheduler (depth 4, tick 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_cmd_scheduler;

    localparam int          FIFO_DEPTH  = 4;
    localparam int          SYNC_STAGES = 2;
    localparam int          TICK_DIV    = 4;
    localparam logic [63:0] RESET_PINS  = 64'h0;
    localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pin_cmd_scheduler_if #(.CNT_W(CNT_W)) bus ();

    pin_cmd_scheduler #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TICK_DIV    (TICK_DIV),
        .RESET_PINS  (RESET_PINS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte set at negedge Nk is written into the FIFO at posedge P(k+3); returns at N(k+2).
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.command_byte = b;
        bus.byte_ready   = 1'b1;
        @(negedge clk);
        bus.byte_ready   = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        repeat (3) @(negedge clk);
        while (bus.busy === 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 300) begin
            n_fail++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", bus.busy, k);
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.byte_ready   = 1'b1;
        bus.command_byte = 8'h01;
        #1;
        n_checks++;
        if (bus.pins !== RESET_PINS) begin
            n_fail++;
            $display("FAIL reset_pins_async: got %h required %h", bus.pins, RESET_PINS);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fifo_count: got %0d required 0", bus.fifo_count);
        end
        n_checks++;
        if (bus.pins !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_pins: got %h required 0", bus.pins);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 0", bus.busy);
        end
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overflow: got %b required 0", bus.overflow);
        end
        bus.byte_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_toggle_set();
        @(negedge clk);                       // N0
        bus.command_byte = 8'h05;
        bus.byte_ready   = 1'b1;
        @(negedge clk);                       // N1
        bus.byte_ready   = 1'b0;
        @(negedge clk);                       // N2
        @(negedge clk);                       // N3: written at P3
        n_checks++;
        if (bus.fifo_count !== 3'd1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_write: count %0d busy %b, required count 1 busy 1",
                     bus.fifo_count, bus.busy);
        end
        n_checks++;
        if (bus.pins !== 64'h0) begin
            n_fail++;
            $display("FAIL latency_e0: pins %h required 0", bus.pins);
        end
        bus.command_byte = 8'h45;
        bus.byte_ready   = 1'b1;
        @(negedge clk);                       // N4: popped at P4
        bus.byte_ready   = 1'b0;
        n_checks++;
        if (bus.pins !== 64'h0 || bus.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL latency_e1: pins %h count %0d, required pins 0 count 0",
                     bus.pins, bus.fifo_count);
        end
        @(negedge clk);                       // N5: pins updated at P5
        n_checks++;
        if (bus.pins !== 64'h20) begin
            n_fail++;
            $display("FAIL latency_e2: pins %h required 20", bus.pins);
        end
        wait_idle();
        n_checks++;
        if (bus.pins !== 64'h20 || bus.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL toggle_then_set: pins %h count %0d, required pins 20 count 0",
                     bus.pins, bus.fifo_count);
        end
    endtask

    task automatic test_wait();
        int k;
        send_byte(8'h4A);                     // N0..N2
        send_byte(8'hC2);                     // N3..N5
        n_checks++;
        if (bus.pins !== 64'h420) begin
            n_fail++;
            $display("FAIL wait_set10: pins %h required 420", bus.pins);
        end
        send_byte(8'h8A);                     // N6..N8
        k = 8;
        while (bus.pins[10] === 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== 22) begin
            n_fail++;
            $display("FAIL wait_duration: pin 10 cleared at cycle %0d required 22", k);
        end
        wait_idle();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.pins !== 64'h20) begin
            n_fail++;
            $display("FAIL wait_end: busy %b pins %h, required busy 0 pins 20",
                     bus.busy, bus.pins);
        end
    endtask

    task automatic test_overflow();
        send_byte(8'hC3);                     // WAIT 16 cycles, P5..P21
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        send_byte(8'h44);
        send_byte(8'h45);                     // dropped at P18
        send_byte(8'h46);                     // dropped at P21
        @(negedge clk);                       // N21
        n_checks++;
        if (bus.fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d required 4", bus.fifo_count);
        end
        n_checks++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b required 1", bus.overflow);
        end
        wait_idle();
        n_checks++;
        if (bus.pins !== 64'h3E || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain: pins %h overflow %b, required pins 3e overflow 1",
                     bus.pins, bus.overflow);
        end
        send_byte(8'hFF);
        wait_idle();
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.pins !== RESET_PINS) begin
            n_fail++;
            $display("FAIL clear_all: pins %h overflow %b, required pins %h overflow 0",
                     bus.pins, bus.overflow, RESET_PINS);
        end
    endtask

    task automatic test_reset_mid_wait();
        send_byte(8'h47);
        wait_idle();
        n_checks++;
        if (bus.pins !== 64'h80) begin
            n_fail++;
            $display("FAIL pre_reset_set7: pins %h required 80", bus.pins);
        end
        send_byte(8'hC5);                     // WAIT 24 cycles
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        @(negedge clk);                       // N12
        n_checks++;
        if (bus.fifo_count !== 3'd3 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait_queue: count %0d busy %b, required count 3 busy 1",
                     bus.fifo_count, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.pins !== RESET_PINS || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: pins %h count %0d busy %b, required pins %h count 0 busy 0",
                     bus.pins, bus.fifo_count, bus.busy, RESET_PINS);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (bus.pins !== RESET_PINS || bus.busy !== 1'b0 || bus.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_discard: pins %h busy %b count %0d, required pins %h busy 0 count 0",
                     bus.pins, bus.busy, bus.fifo_count, RESET_PINS);
        end
    endtask

    task automatic test_full_pop_write();
        send_byte(8'hC3);                     // WAIT ends at P21, pop at P22
        send_byte(8'h41);
        send_byte(8'h81);
        send_byte(8'h42);
        send_byte(8'h82);                     // returns at N14
        repeat (4) @(negedge clk);            // N18
        n_checks++;
        if (bus.fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_before: count %0d required 4", bus.fifo_count);
        end
        @(negedge clk);                       // N19: written at P22
        bus.command_byte = 8'h41;
        bus.byte_ready   = 1'b1;
        @(negedge clk);                       // N20
        bus.byte_ready   = 1'b0;
        @(negedge clk);                       // N21
        n_checks++;
        if (bus.fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_pre_pop: count %0d required 4", bus.fifo_count);
        end
        @(negedge clk);                       // N22
        n_checks++;
        if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_write: count %0d overflow %b, required count 4 overflow 0",
                     bus.fifo_count, bus.overflow);
        end
        wait_idle();
        n_checks++;
        if (bus.pins !== 64'h2 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_order: pins %h overflow %b, required pins 2 overflow 0",
                     bus.pins, bus.overflow);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_toggle_set();
        test_wait();
        test_overflow();
        test_reset_mid_wait();
        test_full_pop_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
